frame_capture: RTL

Downstream consumer of the sensor output buffer. Detects each sensor transfer strobe, captures the pixel bus, and tags every beat with start-of-frame, end-of-line and end-of-frame flags from row/beat counters. Queues beats in a small FIFO and presents them on a valid/ready stream to the readout/storage logic. Includes frame-resynchronisation on the sensor's frame-finished signal and sticky error reporting.

---
 rtl/frame_capture_pkg.sv | 38 +++
 rtl/frame_capture_fifo.sv | 56 +++++
 rtl/frame_capture.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/frame_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_pkg
//  Description : Pixel sensor configuration shared by the frame capture path:
//                array geometry, output bus width, beat types and counter
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_capture_pkg;

    localparam int PIXEL_BITS         = 8;
    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int OUTPUT_BUS_WIDTH   = 2;

    // Number of bus transfers needed to move one sensor row
    localparam int BEATS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = cnt_width(BEATS_PER_ROW);
    localparam int ROW_W = cnt_width(PIXEL_ARRAY_HEIGHT);

    typedef logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] pixel_beat_t;

    // One queued beat: pixels plus position flags
    typedef struct packed {
        pixel_beat_t data;
        logic        sof;
        logic        eol;
        logic        eof;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/frame_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : capture_fifo
//  Description : Synchronous FIFO with full/empty status. A push into a full
//                FIFO is accepted when a pop happens in the same cycle.
//                Read data is forced to zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; pointers are the only state that needs a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture
//  Description : Captures sensor pixel beats on the synchronised transfer
//                strobe, tags them with SOF/EOL/EOF from row/beat counters,
//                queues them and presents them on a valid/ready stream.
//                Resynchronises on frame-finished and keeps sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        OUTPUT_CLK,
    input  pixel_beat_t DATA_IN,
    input  logic        FRAME_FINISHED,
    output logic        M_VALID,
    input  logic        M_READY,
    output pixel_beat_t M_DATA,
    output logic        M_SOF,
    output logic        M_EOL,
    output logic        M_EOF,
    input  logic        CLEAR_FLAGS,
    output logic        OVERFLOW,
    output logic        FRAME_ERROR
);

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

    logic [SYNC_STAGES-1:0] r_oclk_sync;
    logic [SYNC_STAGES-1:0] r_ff_sync;
    logic                   r_oclk_prev;
    logic                   r_ff_prev;
    logic                   r_capture;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic                   r_overflow;
    logic                   r_frame_error;

    logic  w_oclk_rise;
    logic  w_ff_rise;
    logic  w_at_origin;
    logic  w_last_col;
    logic  w_last_row;
    logic  w_full;
    logic  w_empty;
    logic  w_drop;
    beat_t w_push_beat;
    beat_t w_head_beat;

    assign w_oclk_rise = r_oclk_sync[SYNC_STAGES-1] & ~r_oclk_prev;
    assign w_ff_rise   = r_ff_sync[SYNC_STAGES-1] & ~r_ff_prev;

    // Synchronisers, edge detectors and the registered capture pulse; the
    // pulse register leaves DATA_IN stable well inside the sensor hold window
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_oclk_sync <= '0;
            r_ff_sync   <= '0;
            r_oclk_prev <= 1'b0;
            r_ff_prev   <= 1'b0;
            r_capture   <= 1'b0;
        end else begin
            r_oclk_sync <= {r_oclk_sync[SYNC_STAGES-2:0], OUTPUT_CLK};
            r_ff_sync   <= {r_ff_sync[SYNC_STAGES-2:0], FRAME_FINISHED};
            r_oclk_prev <= r_oclk_sync[SYNC_STAGES-1];
            r_ff_prev   <= r_ff_sync[SYNC_STAGES-1];
            r_capture   <= w_oclk_rise;
        end
    end

    assign w_at_origin = (r_row == '0) && (r_col == '0);
    assign w_last_col  = (r_col == c_LAST_COL);
    assign w_last_row  = (r_row == c_LAST_ROW);

    assign w_push_beat.data = DATA_IN;
    assign w_push_beat.sof  = w_at_origin;
    assign w_push_beat.eol  = w_last_col;
    assign w_push_beat.eof  = w_last_col & w_last_row;

    // Position counters; resync overrides the advance so a coincident beat
    // keeps its pre-reset tag while the next beat starts a new frame
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_ff_rise) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_capture) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .i_push  (r_capture),
        .i_wdata (w_push_beat),
        .i_pop   (M_READY),
        .o_rdata (w_head_beat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A full FIFO implies a valid head, so a pop only depends on M_READY
    assign w_drop = r_capture & w_full & ~M_READY;

    // Sticky flags; a new set beats a clear in the same cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_drop)           r_overflow <= 1'b1;
            else if (CLEAR_FLAGS) r_overflow <= 1'b0;
            if (w_ff_rise && !w_at_origin) r_frame_error <= 1'b1;
            else if (CLEAR_FLAGS)          r_frame_error <= 1'b0;
        end
    end

    assign M_VALID     = ~w_empty;
    assign M_DATA      = w_head_beat.data;
    assign M_SOF       = w_head_beat.sof;
    assign M_EOL       = w_head_beat.eol;
    assign M_EOF       = w_head_beat.eof;
    assign OVERFLOW    = r_overflow;
    assign FRAME_ERROR = r_frame_error;

endmodule
`default_nettype wire
